config_bitstream_tx: RTL and testbench

Transmit-side counterpart of the configuration frame loader. It takes a stream of frame words (address word plus `NumberOfRows` data words per frame) from an upstream source and wraps it in the configuration protocol: sync word `0xFAB0_FAB1`, frames, then a desync word. It drives the 32-bit `WriteData`/`WriteStrobe` pair that feeds the fabric's configuration FSM. Strobe spacing is programmable, so the block can pace a slow or UART-emulating path.

---
 rtl/config_bitstream_tx_if.sv | 24 ++
 rtl/config_bitstream_tx.sv | 110 +++++++++++
 tb/tb_config_bitstream_tx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/config_bitstream_tx_if.sv
// config_bitstream_tx_if: upstream handshake, transfer control and loader write port of the bitstream transmitter.
interface config_bitstream_tx_if #(
    parameter int GapWidth = 4
);
    logic                Start;
    logic [15:0]         NumFrames;
    logic [GapWidth-1:0] Gap;
    logic [31:0]         InData;
    logic                InValid;
    logic                InReady;
    logic [31:0]         WriteData;
    logic                WriteStrobe;
    logic                Busy;
    logic                Done;
    logic                Error;
    modport master (
        output Start, NumFrames, Gap, InData, InValid,
        input  InReady, WriteData, WriteStrobe, Busy, Done, Error
    );
    modport slave (
        input  Start, NumFrames, Gap, InData, InValid,
        output InReady, WriteData, WriteStrobe, Busy, Done, Error
    );
endinterface

// File: rtl/config_bitstream_tx.sv
// config_bitstream_tx: wraps upstream frame words in sync/desync words and paces WriteStrobe by a programmable gap.
module config_bitstream_tx #(
    parameter int NumberOfRows = 14,
    parameter int desync_flag  = 20,
    parameter int GapWidth     = 4
) (
    input logic                  CLK,
    input logic                  Resetn,
    config_bitstream_tx_if.slave bus
);
    localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD = 32'h1 << desync_flag;
    localparam int          RW          = $clog2(NumberOfRows + 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(NumberOfRows - 1);

    typedef enum logic [2:0] {IDLE, SYNC, ADDR, DATA, DESYNC} state_t;

    state_t              state_q;
    logic [15:0]         nf_q;
    logic [15:0]         frame_q;
    logic [RW-1:0]       row_q;
    logic [GapWidth-1:0] gap_q;
    logic [GapWidth-1:0] gap_cnt_q;
    logic [31:0]         wdata_q;
    logic                strobe_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                accept;

    assign bus.InReady     = (gap_cnt_q == '0) && (state_q == ADDR || state_q == DATA);
    assign accept          = bus.InReady && bus.InValid;
    assign bus.WriteData   = wdata_q;
    assign bus.WriteStrobe = strobe_q;
    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.Error       = err_q;

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            nf_q      <= '0;
            frame_q   <= '0;
            row_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            wdata_q   <= '0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - 1'b1;
            case (state_q)
                IDLE: begin
                    // busy_q still high here means the desync strobe is on the bus this cycle
                    if (bus.Start && !busy_q) begin
                        nf_q      <= bus.NumFrames;
                        gap_q     <= bus.Gap;
                        gap_cnt_q <= bus.Gap;
                        frame_q   <= '0;
                        err_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        wdata_q   <= SYNC_WORD;
                        strobe_q  <= 1'b1;
                        state_q   <= (bus.NumFrames != '0) ? ADDR : DESYNC;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ADDR: begin
                    if (accept && bus.InData[desync_flag]) begin
                        err_q   <= 1'b1;
                        state_q <= DESYNC;
                    end else if (accept) begin
                        wdata_q   <= bus.InData;
                        strobe_q  <= 1'b1;
                        gap_cnt_q <= gap_q;
                        row_q     <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        wdata_q   <= bus.InData;
                        strobe_q  <= 1'b1;
                        gap_cnt_q <= gap_q;
                        row_q     <= row_q + RW'(1);
                        if (row_q == LAST_ROW) begin
                            frame_q <= frame_q + 16'd1;
                            state_q <= (frame_q + 16'd1 == nf_q) ? DESYNC : ADDR;
                        end
                    end
                end
                DESYNC: begin
                    if (gap_cnt_q == '0) begin
                        wdata_q   <= DESYNC_WORD;
                        strobe_q  <= 1'b1;
                        done_q    <= 1'b1;
                        gap_cnt_q <= gap_q;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_config_bitstream_tx.sv
// tb_config_bitstream_tx: table of transfers checked against a bench-built word list, plus reset and restart corner cases.
module tb_config_bitstream_tx;
    localparam int          ROWS     = 14;
    localparam logic [31:0] SYNC_W   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_W = 32'h0010_0000;
    localparam logic [31:0] ABORT_W  = 32'h0010_0005;

    logic CLK = 1'b0;
    logic Resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    config_bitstream_tx_if #(.GapWidth(4)) bus();
    config_bitstream_tx #(.NumberOfRows(ROWS), .desync_flag(20), .GapWidth(4)) dut (
        .CLK(CLK), .Resetn(Resetn), .bus(bus)
    );

    typedef struct {
        int nf;
        int gap;
        int abort_at;
        bit rnd;
        int restart;
        int exp_n;
        int exp_done;
        int exp_err_cyc;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wdata"}, bus.WriteData, 0);
        chk({tag, "_strobe"}, bus.WriteStrobe, 0);
        chk({tag, "_ready"}, bus.InReady, 0);
        chk({tag, "_busy"}, bus.Busy, 0);
        chk({tag, "_done"}, bus.Done, 0);
        chk({tag, "_error"}, bus.Error, 0);
    endtask

    task automatic run(input vec_t v);
        logic [31:0] expq[$];
        logic [31:0] upq[$];
        logic [31:0] got[$];
        int gotc[$];
        int done_cyc = 0, done_n = 0, busy_low = 0, err_cyc = 0;
        int bad_strobe = 0, ready_n = 0, spacing = 0, n_up, rel, start_cyc;
        bit acc = 1'b0, timeout = 1'b1;
        expq.push_back(SYNC_W);
        for (int f = 0; f < v.nf; f++) begin
            if (f == v.abort_at) begin
                upq.push_back(ABORT_W);
                break;
            end
            upq.push_back(32'hA000_0000 + 32'(f * 256));
            expq.push_back(32'hA000_0000 + 32'(f * 256));
            for (int r = 0; r < ROWS; r++) begin
                upq.push_back(32'hD000_0000 + 32'(f * 256 + r));
                expq.push_back(32'hD000_0000 + 32'(f * 256 + r));
            end
        end
        expq.push_back(DESYNC_W);
        n_up = upq.size();
        bus.InValid   = 1'b0;
        bus.NumFrames = 16'(v.nf);
        bus.Gap       = 4'(v.gap);
        bus.Start     = 1'b1;
        start_cyc     = cyc;
        for (int i = 0; i < 400; i++) begin
            @(posedge CLK);
            #1;
            bus.Start = (v.restart != 0) && (cyc - start_cyc == v.restart);
            if (bus.Start) bus.NumFrames = 16'd0;
            if (acc) void'(upq.pop_front());
            bus.InValid = (upq.size() != 0) && (!v.rnd || $urandom_range(0, 1) == 1);
            bus.InData  = (upq.size() != 0) ? upq[0] : 32'h0;
            @(negedge CLK);
            rel = cyc - start_cyc;
            if (done_n == 0 && !bus.Busy) busy_low++;
            if (bus.WriteStrobe) begin
                got.push_back(bus.WriteData);
                gotc.push_back(rel);
                if (got.size() > 1 && !bus.Done && !acc) bad_strobe++;
            end
            if (bus.InReady) ready_n++;
            if (bus.Error && err_cyc == 0) err_cyc = rel;
            if (done_n > 0 && rel == done_cyc + 1) begin
                chk("busy_after_done", bus.Busy, 0);
                timeout = 1'b0;
                break;
            end
            if (bus.Done) begin
                done_n++;
                done_cyc = rel;
            end
            acc = bus.InValid && bus.InReady;
        end
        bus.Start = 1'b0;
        if (timeout) chk("timeout", 1, 0);
        chk("strobe_count", got.size(), v.exp_n);
        for (int k = 0; k < got.size() && k < expq.size(); k++) chk($sformatf("word%0d", k), got[k], expq[k]);
        if (v.exp_done > 0) chk("done_cycle", done_cyc, v.exp_done);
        chk("done_pulses", done_n, 1);
        chk("busy_low_in_xfer", busy_low, 0);
        chk("error_cycle", err_cyc, v.exp_err_cyc);
        chk("strobe_without_accept", bad_strobe, 0);
        if (!v.rnd && v.abort_at < 0) begin
            foreach (gotc[k]) if (gotc[k] != 1 + k * (v.gap + 1)) spacing++;
            chk("strobe_spacing", spacing, 0);
        end
        if (!v.rnd) chk("ready_cycles", ready_n, n_up);
    endtask

    initial begin
        tv[0] = '{nf: 2, gap: 0, abort_at: -1, rnd: 0, restart: 0, exp_n: 32, exp_done: 32, exp_err_cyc: 0};
        tv[1] = '{nf: 1, gap: 3, abort_at: -1, rnd: 0, restart: 0, exp_n: 17, exp_done: 65, exp_err_cyc: 0};
        tv[2] = '{nf: 0, gap: 0, abort_at: -1, rnd: 0, restart: 0, exp_n: 2,  exp_done: 2,  exp_err_cyc: 0};
        tv[3] = '{nf: 3, gap: 0, abort_at: 1,  rnd: 0, restart: 0, exp_n: 17, exp_done: 18, exp_err_cyc: 17};
        tv[4] = '{nf: 2, gap: 1, abort_at: -1, rnd: 1, restart: 0, exp_n: 32, exp_done: 0,  exp_err_cyc: 0};
        tv[5] = '{nf: 1, gap: 0, abort_at: -1, rnd: 0, restart: 5, exp_n: 17, exp_done: 17, exp_err_cyc: 0};
        bus.Start     = 1'b0;
        bus.NumFrames = 16'd0;
        bus.Gap       = 4'd0;
        bus.InData    = 32'h0;
        bus.InValid   = 1'b0;
        #1;
        chk_idle_outputs("reset");
        repeat (3) @(negedge CLK);
        Resetn = 1'b1;
        @(negedge CLK);
        foreach (tv[i]) begin
            run(tv[i]);
            repeat (2) @(negedge CLK);
        end
        // Reset pulled while the block is streaming data words
        bus.NumFrames = 16'd2;
        bus.Gap       = 4'd0;
        bus.InData    = 32'h1204_5678;
        bus.InValid   = 1'b1;
        bus.Start     = 1'b1;
        @(posedge CLK);
        #1;
        bus.Start = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        chk("mid_busy", bus.Busy, 1);
        chk("mid_wdata", bus.WriteData, 32'h1204_5678);
        Resetn = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        bus.InValid = 1'b0;
        repeat (2) @(negedge CLK);
        Resetn = 1'b1;
        @(negedge CLK);
        run('{nf: 0, gap: 2, abort_at: -1, rnd: 0, restart: 0, exp_n: 2, exp_done: 4, exp_err_cyc: 0});
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
